// File: rtl/sram_1rw_arbiter.sv
// Round-robin arbiter sharing one 1RW write-masked SRAM macro between requesters A and B.
// Reads return exactly two cycles after acceptance, in issue order; writes produce no response.
module sram_1rw_arbiter #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned NUM_WMASKS = 2
) (
    input  logic                  clk0,
    input  logic                  rst_n,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_web,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_web,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic [NUM_WMASKS-1:0] wmask0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    logic                  run_q;
    logic                  grant_a_c;
    logic                  grant_b_c;
    logic                  web_c;

    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] din_q,        din_d;
    logic [NUM_WMASKS-1:0] wmask_q,      wmask_d;

    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_id_q,    pend_id_d;
    logic                  a_rvalid_q,   a_rvalid_d;
    logic                  b_rvalid_q,   b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q,    a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q,    b_rdata_d;

    // Grants are held off until the first edge after reset release (sync deassert toward the macro)
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Round-robin arbitration: on a tie the requester that did not win last goes
    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        if (run_q) begin
            if (a_valid && b_valid) begin
                if (last_grant_q == REQ_B) begin
                    grant_a_c = 1'b1;
                end else begin
                    grant_b_c = 1'b1;
                end
            end else if (a_valid) begin
                grant_a_c = 1'b1;
            end else if (b_valid) begin
                grant_b_c = 1'b1;
            end
        end
    end

    // Command mux, held macro bus and read-return pipeline
    always_comb begin
        last_grant_d = last_grant_q;
        web_c        = 1'b1;
        addr_d       = addr_q;
        din_d        = din_q;
        wmask_d      = wmask_q;

        if (grant_a_c) begin
            last_grant_d = REQ_A;
            web_c        = a_web;
            addr_d       = a_addr;
            din_d        = a_wdata;
            wmask_d      = a_web ? '0 : a_wmask;
        end else if (grant_b_c) begin
            last_grant_d = REQ_B;
            web_c        = b_web;
            addr_d       = b_addr;
            din_d        = b_wdata;
            wmask_d      = b_web ? '0 : b_wmask;
        end

        pend_valid_d = (grant_a_c && a_web) || (grant_b_c && b_web);
        pend_id_d    = grant_b_c ? REQ_B : REQ_A;

        // dout0 is valid the cycle after a read is accepted; capture it then
        a_rvalid_d = pend_valid_q && (pend_id_q == REQ_A);
        b_rvalid_d = pend_valid_q && (pend_id_q == REQ_B);
        a_rdata_d  = a_rvalid_d ? dout0 : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? dout0 : b_rdata_q;
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_B;
            addr_q       <= '0;
            din_q        <= '0;
            wmask_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= REQ_A;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            wmask_q      <= wmask_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign a_ready  = grant_a_c;
    assign b_ready  = grant_b_c;

    assign csb0     = !(grant_a_c || grant_b_c);
    assign web0     = web_c;
    assign addr0    = addr_d;
    assign din0     = din_d;
    assign wmask0   = wmask_d;

    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed bench for sram_1rw_arbiter with a behavioural 1RW write-masked macro model.
// Memory is preloaded with known contents so masked and unwritten bits have concrete values.
module tb_sram_1rw_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 2;
    localparam int unsigned NW = 2;

    logic          clk0;
    logic          rst_n;
    logic          a_valid, a_ready, a_web, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic [NW-1:0] a_wmask;
    logic          b_valid, b_ready, b_web, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [NW-1:0] b_wmask;
    logic          csb0, web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0, dout0;
    logic [NW-1:0] wmask0;

    logic          mem_init;
    logic [DW-1:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    sram_1rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
        .clk0    (clk0),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_web   (a_web),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_wmask (a_wmask),
        .a_rvalid(a_rvalid),
        .a_rdata (a_rdata),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_web   (b_web),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_wmask (b_wmask),
        .b_rvalid(b_rvalid),
        .b_rdata (b_rdata),
        .csb0    (csb0),
        .web0    (web0),
        .addr0   (addr0),
        .din0    (din0),
        .wmask0  (wmask0),
        .dout0   (dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Macro model: masked write commits at the edge; read data appears after the edge
    always @(posedge clk0) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= DW'(i);
            mem[12] <= 2'b01;
            dout0   <= '0;
        end else if (!csb0) begin
            if (!web0) begin
                for (int j = 0; j < int'(NW); j++) begin
                    if (wmask0[j]) mem[addr0][j] <= din0[j];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk0);
        #1;
    endtask

    task automatic a_read2(input string tag, input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                           input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        a_valid = 1'b1; a_web = 1'b1; a_addr = ad0;
        @(negedge clk0);
        check({tag, "_ready0"}, 8'(a_ready), 8'(1));
        next_cycle();
        a_addr = ad1;
        @(negedge clk0);
        check({tag, "_ready1"}, 8'(a_ready), 8'(1));
        check({tag, "_rv_early"}, 8'(a_rvalid), 8'(0));
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk0);
        check({tag, "_rv0"}, 8'(a_rvalid), 8'(1));
        check({tag, "_rd0"}, 8'(a_rdata), 8'(e0));
        next_cycle();
        @(negedge clk0);
        check({tag, "_rv1"}, 8'(a_rvalid), 8'(1));
        check({tag, "_rd1"}, 8'(a_rdata), 8'(e1));
        check({tag, "_b_rv"}, 8'(b_rvalid), 8'(0));
        next_cycle();
        @(negedge clk0);
        check({tag, "_rv_end"}, 8'(a_rvalid), 8'(0));
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; mem_init = 1'b1;
        a_valid = 1'b0; a_web = 1'b1; a_addr = '0; a_wdata = '0; a_wmask = '0;
        b_valid = 1'b0; b_web = 1'b1; b_addr = '0; b_wdata = '0; b_wmask = '0;

        // Reset
        repeat (3) next_cycle();
        @(negedge clk0);
        check("rst_csb0", 8'(csb0), 8'(1));
        check("rst_web0", 8'(web0), 8'(1));
        next_cycle();
        rst_n = 1'b1; mem_init = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk0);
            check("post_rst_a_ready", 8'(a_ready), 8'(0));
            check("post_rst_b_ready", 8'(b_ready), 8'(0));
            check("post_rst_a_rvalid", 8'(a_rvalid), 8'(0));
            check("post_rst_b_rvalid", 8'(b_rvalid), 8'(0));
            check("post_rst_csb0", 8'(csb0), 8'(1));
            next_cycle();
        end

        // A masked write to addr 1 (preload 01), then read-back -> 11
        a_valid = 1'b1; a_web = 1'b0; a_addr = 4'h1; a_wdata = 2'b10; a_wmask = 2'b10;
        @(negedge clk0);
        check("wr_a_ready", 8'(a_ready), 8'(1));
        check("wr_b_ready", 8'(b_ready), 8'(0));
        check("wr_csb0", 8'(csb0), 8'(0));
        check("wr_web0", 8'(web0), 8'(0));
        check("wr_addr0", 8'(addr0), 8'(1));
        check("wr_wmask0", 8'(wmask0), 8'(2'b10));
        next_cycle();
        a_web = 1'b1;
        @(negedge clk0);
        check("rd_a_ready", 8'(a_ready), 8'(1));
        check("rd_web0", 8'(web0), 8'(1));
        check("rd_wmask0", 8'(wmask0), 8'(0));
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk0);
        check("wr_no_resp", 8'(a_rvalid), 8'(0));
        check("idle_csb0", 8'(csb0), 8'(1));
        check("idle_addr0_hold", 8'(addr0), 8'(1));
        next_cycle();
        @(negedge clk0);
        check("rb_a_rvalid", 8'(a_rvalid), 8'(1));
        check("rb_a_rdata", 8'(a_rdata), 8'(2'b11));
        check("rb_b_rvalid", 8'(b_rvalid), 8'(0));
        next_cycle();
        @(negedge clk0);
        check("rb_rvalid_pulse", 8'(a_rvalid), 8'(0));
        check("rb_rdata_hold", 8'(a_rdata), 8'(2'b11));
        next_cycle();

        // B masked write to addr 1: low bit only, word stays 11
        b_valid = 1'b1; b_web = 1'b0; b_addr = 4'h1; b_wdata = 2'b01; b_wmask = 2'b01;
        @(negedge clk0);
        check("bwr_b_ready", 8'(b_ready), 8'(1));
        check("bwr_a_ready", 8'(a_ready), 8'(0));
        check("bwr_din0", 8'(din0), 8'(2'b01));
        check("bwr_wmask0", 8'(wmask0), 8'(2'b01));
        next_cycle();

        // Tie: A reads 0xC (01), B reads 0x1 (11); last grant was B so A goes first
        a_valid = 1'b1; a_web = 1'b1; a_addr = 4'hC;
        b_valid = 1'b1; b_web = 1'b1; b_addr = 4'h1;
        for (int k = 0; k < 6; k++) begin
            a_valid = (k < 4);
            b_valid = (k < 4);
            @(negedge clk0);
            check("tie_a_ready", 8'(a_ready), 8'((k < 4) && (k % 2 == 0)));
            check("tie_b_ready", 8'(b_ready), 8'((k < 4) && (k % 2 == 1)));
            check("tie_a_rvalid", 8'(a_rvalid), 8'((k >= 2) && (k % 2 == 0)));
            check("tie_b_rvalid", 8'(b_rvalid), 8'((k >= 2) && (k % 2 == 1)));
            check("tie_a_rdata", 8'(a_rdata), (k >= 2) ? 8'(2'b01) : 8'(2'b11));
            check("tie_b_rdata", 8'(b_rdata), (k >= 3) ? 8'(2'b11) : 8'(2'b00));
            next_cycle();
        end

        // Full-word result of both writes and an unwritten word, then back-to-back ordering
        a_read2("fw", 4'h1, 4'h0, 2'b11, 2'b00);
        a_read2("b2b", 4'hC, 4'h1, 2'b01, 2'b11);

        // A write and B read to addr 5 together; last grant was A so B reads old data first
        a_valid = 1'b1; a_web = 1'b0; a_addr = 4'h5; a_wdata = 2'b10; a_wmask = 2'b11;
        b_valid = 1'b1; b_web = 1'b1; b_addr = 4'h5;
        @(negedge clk0);
        check("haz_b_ready", 8'(b_ready), 8'(1));
        check("haz_a_wait", 8'(a_ready), 8'(0));
        next_cycle();
        b_valid = 1'b0;
        @(negedge clk0);
        check("haz_a_ready", 8'(a_ready), 8'(1));
        check("haz_a_web0", 8'(web0), 8'(0));
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b1;
        @(negedge clk0);
        check("haz_old_rvalid", 8'(b_rvalid), 8'(1));
        check("haz_old_rdata", 8'(b_rdata), 8'(2'b01));
        check("haz_b_ready2", 8'(b_ready), 8'(1));
        next_cycle();
        b_valid = 1'b0;
        @(negedge clk0);
        check("haz_gap", 8'(b_rvalid), 8'(0));
        next_cycle();
        @(negedge clk0);
        check("haz_new_rvalid", 8'(b_rvalid), 8'(1));
        check("haz_new_rdata", 8'(b_rdata), 8'(2'b10));
        next_cycle();

        // Reset the cycle after a read is accepted: the read is dropped
        a_valid = 1'b1; a_web = 1'b1; a_addr = 4'hC;
        @(negedge clk0);
        check("mr_a_ready", 8'(a_ready), 8'(1));
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk0);
        check("mr_csb0", 8'(csb0), 8'(1));
        check("mr_a_ready_rst", 8'(a_ready), 8'(0));
        next_cycle();
        a_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk0);
            check("mr_rst_rvalid", 8'(a_rvalid), 8'(0));
            check("mr_rst_csb0", 8'(csb0), 8'(1));
            next_cycle();
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk0);
            check("mr_post_a_rvalid", 8'(a_rvalid), 8'(0));
            check("mr_post_b_rvalid", 8'(b_rvalid), 8'(0));
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_1rw_arbiter.md
Name: sram_1rw_arbiter

Overview:
- Round-robin arbiter that shares one 1RW write-masked OpenRAM macro between two requesters, A and B.
- Each requester has a valid/ready request channel carrying read or masked-write commands, and a read-response channel.
- The arbiter drives csb0/web0/addr0/din0/wmask0 to the macro, captures dout0, and returns read data to the requester that issued the read.
- Sits between client logic and the generated SRAM wrapper; at most one macro access per cycle.

Parameters:
- ADDR_WIDTH, 4, macro address width (16 words).
- DATA_WIDTH, 2, macro word width.
- NUM_WMASKS, 2, write-mask width; DATA_WIDTH must be a multiple of NUM_WMASKS; each mask bit covers DATA_WIDTH/NUM_WMASKS bits.

Ports:
- clk0  in  1  sole clock; also drives the macro clk0.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A command valid.
- a_ready  out  1  A command accepted this cycle.
- a_web  in  1  0 = write, 1 = read.
- a_addr  in  ADDR_WIDTH  A address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_wmask  in  NUM_WMASKS  A write mask; ignored on reads.
- a_rvalid  out  1  A read data valid (1-cycle pulse).
- a_rdata  out  DATA_WIDTH  A read data.
- b_valid, b_ready, b_web, b_addr, b_wdata, b_wmask, b_rvalid, b_rdata: same as the A ports, for requester B.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- wmask0  out  NUM_WMASKS  macro write mask.
- dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (async assert, sync deassert at the macro boundary):
  - a_ready = b_ready = 0; a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - csb0 = 1, web0 = 1.
  - last_grant = B, so A wins the first tie.
  - Pending-read pipeline cleared.
- Arbitration (combinational within the cycle):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester that is not last_grant.
  - last_grant updates on every accepted command.
  - x_ready = grant_x. No ready without valid; never both readies in one cycle.
- Macro drive (combinational from the granted command):
  - csb0 = 0; web0 = x_web; addr0 = x_addr; din0 = x_wdata; wmask0 = x_wmask.
  - On a read, wmask0 is driven 0.
  - No grant -> csb0 = 1, web0 = 1; addr0/din0/wmask0 hold their last values (no toggling when idle).
- Write path:
  - The macro commits at the edge ending the accept cycle.
  - Bits whose mask bit is 0 are unchanged in the array.
  - No response is generated for writes.
- Read path, fixed latency 2:
  - Accept in cycle N. dout0 is valid in cycle N+1 and is registered at the end of N+1.
  - x_rvalid = 1 and x_rdata = captured word for exactly cycle N+2.
  - A 2-stage pending tag (valid bit + requester id) tracks outstanding reads. Back-to-back reads from either requester return in issue order, one per cycle.
  - x_rdata holds its value when rvalid is low.
- Ordering and hazards:
  - Accesses are serialised by the single port, so a read accepted after a write to the same address returns the new data.
  - A simultaneous A write and B read to the same address resolves in grant order.
- Starvation:
  - A requester holding valid is granted within 2 cycles.
  - The requester must hold its command stable while valid and not ready.
- Reset mid-operation: pending reads are discarded (no rvalid after reset) and csb0 goes high immediately.

Test Plan:
- Reset: after rst_n deasserts, check a_ready = b_ready = a_rvalid = b_rvalid = 0 and csb0 = 1 while no requests are made.
- A masked write, then read-back:
  - A writes addr 1, data 2'b10, wmask 2'b10.
  - A reads addr 1 -> a_rvalid two cycles after accept, a_rdata = 2'b1x; b_rvalid stays 0.
- Tie round-robin:
  - A and B both valid for 4 cycles with reads of addr 0xC and 0x1.
  - Grants alternate A,B,A,B; rvalid pulses alternate A,B,A,B two cycles later.
- Full-word update:
  - B writes addr 1, data 2'b01, wmask 2'b01; A then reads addr 1 -> 2'b11.
  - Unwritten addr 0 reads back 2'bxx.
- Back-to-back ordering:
  - A reads addr 0xC, then addr 1 in consecutive cycles.
  - a_rvalid is high for 2 consecutive cycles with 2'bx1, then 2'b11.
- Reset mid-read: assert rst_n = 0 the cycle after a read is accepted -> no rvalid afterwards, and csb0 = 1 during reset.
